div_seq_ctrl: RTL and testbench
===============================

DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Port: clk  input  1  rising-edge system clock.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin a divide; sampled on clk.
REQ-005 Port: FS  input  5  function select; a divide is 5'h1F.
REQ-006 Port: S  input  32  signed dividend; sampled with start.
REQ-007 Port: T  input  32  signed divisor; sampled with start.
REQ-008 Port: busy  output  1  high while a divide is in progress; the pipeline stall source.
REQ-009 Port: done  output  1  one-cycle pulse when results are valid.
REQ-010 Port: Y_hi  output  32  remainder (HI).
REQ-011 Port: Y_lo  output  32  quotient (LO).
REQ-012 Port: N  output  1  equals Y_lo[31].
REQ-013 Port: Z  output  1  high when Y_lo == 0.
REQ-014 Port (only with DIV_ZERO_TRAP_EN): dbz  output  1  divide-by-zero flag, valid with done.

Function
REQ-015 The FSM SHALL have states IDLE, PREP, ITER, FIX and DONE.
REQ-016 IDLE->PREP SHALL occur only when start==1 and FS==5'h1F; S and T are latched on that edge.
REQ-017 start SHALL be ignored outside IDLE, and when FS!=5'h1F.
REQ-018 PREP SHALL latch |S|, |T|, sign(S) and sign(S)^sign(T), clear the 6-bit iteration counter, then go to ITER.
REQ-019 ITER SHALL run one restoring shift-subtract step per cycle on unsigned magnitudes.
- 64-bit {rem,quo} register; shift left by 1.
- If rem >= |T|: subtract |T| and set quo[0].
- Exactly 32 cycles, then go to FIX.
REQ-020 FIX SHALL apply signs and register Y_lo, Y_hi, N and Z in the same edge.
- Quotient is negated if signs differ; truncation is toward zero.
- Remainder takes the sign of S.
- Go to DONE.
REQ-021 DONE SHALL assert done for exactly one cycle, then return to IDLE; a start in DONE is ignored.
REQ-022 busy SHALL be 1 in PREP, ITER and FIX, and 0 in IDLE and DONE.
REQ-023 Latency: if start is sampled at edge 0, done SHALL be high during cycle 35 (PREP 1, ITER 2-33, FIX 34, DONE 35).
REQ-024 Y_hi, Y_lo, N and Z SHALL hold their values at all times except the FIX edge and reset.
REQ-025 Overflow: S=32'h80000000 with T=32'hFFFFFFFF SHALL give Y_lo=32'h80000000 and Y_hi=0, by 32-bit wrap and with no flag.
REQ-026 Without DIV_ZERO_TRAP_EN, T==0 SHALL run the normal latency and give Y_lo=32'hFFFFFFFF and Y_hi=S.

Reset
REQ-027 Reset SHALL force the FSM to IDLE and clear the counter and the internal operand and sign registers.
REQ-028 Reset SHALL clear busy, done, dbz, N, Y_hi and Y_lo to 0, and set Z=1.
REQ-029 Reset asserted mid-divide SHALL abort the operation: no done pulse, the partial result is discarded, and a start is accepted on the first edge after reset deasserts.
REQ-030 Reset SHALL take priority over start on the same edge.

Configuration
REQ-031 Macro DIV_ZERO_TRAP_EN SHALL gate divide-by-zero trapping.
REQ-032 With DIV_ZERO_TRAP_EN defined, T==0 SHALL be handled as follows.
- Detected in PREP; the next state is DONE (ITER and FIX are skipped).
- done and dbz are high together for one cycle, in cycle 2 after start.
- Y_hi, Y_lo, N and Z are unchanged.
- dbz is 0 on every other done pulse.
REQ-033 With DIV_ZERO_TRAP_EN undefined, there SHALL be no dbz port and REQ-026 applies.

Structure
REQ-034 A shared package SHALL hold the following.
- The state enum (IDLE, PREP, ITER, FIX, DONE).
- FS_DIV = 5'h1F.
- DIV_ITERS = 32.
- The data width 32.
REQ-035 The single per-iteration compare/subtract/shift step SHALL be a combinational sub-module div_step (inputs: rem, quo, divisor; outputs: next rem, next quo).

Verification
REQ-036 S=100, T=7, FS=1F -> busy cycles 1-34; done in cycle 35; Y_lo=14, Y_hi=2, N=0, Z=0.
REQ-037 S=-100, T=7 -> Y_lo=32'hFFFFFFF2, Y_hi=32'hFFFFFFFE, N=1; also S=3, T=7 -> Y_lo=0, Y_hi=3, Z=1.
REQ-038 S=32'h80000000, T=32'hFFFFFFFF -> Y_lo=32'h80000000, Y_hi=0, N=1.
REQ-039 S=5, T=0 -> without macro: done in cycle 35, Y_lo=32'hFFFFFFFF, Y_hi=5; with macro: done and dbz in cycle 2, outputs unchanged.
REQ-040 Start S=100/T=7, reset at cycle 10 -> busy=0 and all outputs at reset values next cycle, no done; a following start with S=9, T=2 -> Y_lo=4, Y_hi=1.
REQ-041 A second start (S=1, T=1) pulsed during ITER -> ignored; the original result is produced once and busy returns to 0 after cycle 34.

Source files
------------

// File: rtl/div_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_ctrl_pkg
// Description : Shared types and constants for the sequential signed divider.
// Revision    : 1.0 - initial release
// ============================================================================
package div_seq_ctrl_pkg;

  localparam int          DATA_W    = 32;
  localparam int          DIV_ITERS = 32;
  localparam int          CNT_W     = 6;
  localparam logic [4:0]  FS_DIV    = 5'h1F;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Two's-complement magnitude; 32'h80000000 wraps to itself and is read as unsigned.
  function automatic logic [DATA_W-1:0] abs_mag(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? (-x) : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_ctrl_if
// Description : Request/result bundle of the divider; dbz exists only when
//               DIV_ZERO_TRAP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_seq_ctrl_if;
  import div_seq_ctrl_pkg::*;

  logic              start;
  logic [4:0]        FS;
  logic [DATA_W-1:0] S;
  logic [DATA_W-1:0] T;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] Y_hi;
  logic [DATA_W-1:0] Y_lo;
  logic              N;
  logic              Z;
`ifdef DIV_ZERO_TRAP_EN
  logic              dbz;

  modport master (output start, FS, S, T,
                  input  busy, done, Y_hi, Y_lo, N, Z, dbz);
  modport slave  (input  start, FS, S, T,
                  output busy, done, Y_hi, Y_lo, N, Z, dbz);
`else
  modport master (output start, FS, S, T,
                  input  busy, done, Y_hi, Y_lo, N, Z);
  modport slave  (input  start, FS, S, T,
                  output busy, done, Y_hi, Y_lo, N, Z);
`endif

endinterface
`default_nettype wire

// File: rtl/div_seq_ctrl_div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One restoring shift/compare/subtract step on unsigned values.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step
  import div_seq_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0]   w_rem_sh;
  logic [DATA_W-1:0] w_diff;
  logic              w_ge;

  assign w_rem_sh = {rem_i, quo_i[DATA_W-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, divisor_i});
  // When w_ge holds the true difference is below 2^DATA_W, so the wrap is exact.
  assign w_diff   = w_rem_sh[DATA_W-1:0] - divisor_i;

  assign rem_o = w_ge ? w_diff : w_rem_sh[DATA_W-1:0];
  assign quo_o = {quo_i[DATA_W-2:0], w_ge};

endmodule
`default_nettype wire

// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_ctrl
// Description : Multi-cycle signed 32/32 divider (quotient LO, remainder HI).
//               Optional macro DIV_ZERO_TRAP_EN adds the dbz trap path.
// Revision    : 1.0 - initial release
// ============================================================================
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  div_seq_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(DIV_ITERS - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] s_q, s_d, t_q, t_d;
  logic [DATA_W-1:0] dvsr_q, dvsr_d, rem_q, rem_d, quo_q, quo_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d;
  logic [DATA_W-1:0] yhi_q, yhi_d, ylo_q, ylo_d;
  logic              n_q, n_d, z_q, z_d;
  logic [DATA_W-1:0] w_rem_nx, w_quo_nx, w_quo_fix, w_rem_fix;
`ifdef DIV_ZERO_TRAP_EN
  logic              dbz_q, dbz_d;
`endif

  div_step u_step (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(dvsr_q),
    .rem_o    (w_rem_nx),
    .quo_o    (w_quo_nx)
  );

  // A zero divisor yields an all-ones quotient whatever the dividend sign.
  assign w_quo_fix = (dvsr_q == '0) ? '1 : (qneg_q ? (-quo_q) : quo_q);
  assign w_rem_fix = rneg_q ? (-rem_q) : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    t_d     = t_q;
    dvsr_d  = dvsr_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    yhi_d   = yhi_q;
    ylo_d   = ylo_q;
    n_d     = n_q;
    z_d     = z_q;
    case (state_q)
      IDLE: begin
        if (bus.start && (bus.FS == FS_DIV)) begin
          s_d     = bus.S;
          t_d     = bus.T;
          state_d = PREP;
        end
      end
      PREP: begin
        dvsr_d  = abs_mag(t_q);
        rem_d   = '0;
        quo_d   = abs_mag(s_q);
        rneg_d  = s_q[DATA_W-1];
        qneg_d  = s_q[DATA_W-1] ^ t_q[DATA_W-1];
        cnt_d   = '0;
        state_d = ITER;
`ifdef DIV_ZERO_TRAP_EN
        if (t_q == '0) state_d = DONE;
`endif
      end
      ITER: begin
        rem_d = w_rem_nx;
        quo_d = w_quo_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ITER_LAST) state_d = FIX;
      end
      FIX: begin
        ylo_d   = w_quo_fix;
        yhi_d   = w_rem_fix;
        n_d     = w_quo_fix[DATA_W-1];
        z_d     = (w_quo_fix == '0);
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef DIV_ZERO_TRAP_EN
  // Only a trapped PREP leads straight to DONE, so dbz is clear on normal pulses.
  assign dbz_d = (state_q == PREP) && (t_q == '0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      t_q     <= '0;
      dvsr_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      yhi_q   <= '0;
      ylo_q   <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b1;
`ifdef DIV_ZERO_TRAP_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      t_q     <= t_d;
      dvsr_q  <= dvsr_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      yhi_q   <= yhi_d;
      ylo_q   <= ylo_d;
      n_q     <= n_d;
      z_q     <= z_d;
`ifdef DIV_ZERO_TRAP_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign bus.busy = (state_q == PREP) || (state_q == ITER) || (state_q == FIX);
  assign bus.done = (state_q == DONE);
  assign bus.Y_hi = yhi_q;
  assign bus.Y_lo = ylo_q;
  assign bus.N    = n_q;
  assign bus.Z    = z_q;
`ifdef DIV_ZERO_TRAP_EN
  assign bus.dbz  = dbz_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_seq_ctrl
// Description : Directed self-checking bench for div_seq_ctrl (both builds of
//               DIV_ZERO_TRAP_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  div_seq_ctrl_if bif ();

  div_seq_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  // Launches one divide (start sampled at edge 0) and watches cycles 1..40.
  task automatic run_op(input logic [31:0] s, input logic [31:0] t, input bit at_neg,
                        input int busy_last, input int inject_cyc,
                        output int done_cyc, output int done_cnt, output int busy_err,
                        output bit dbz_seen);
    done_cyc = -1;
    done_cnt = 0;
    busy_err = 0;
    dbz_seen = 1'b0;
    if (!at_neg) @(negedge clk);
    bif.start = 1'b1;
    bif.FS    = 5'h1F;
    bif.S     = s;
    bif.T     = t;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bif.done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
`ifdef DIV_ZERO_TRAP_EN
        if (bif.dbz === 1'b1) dbz_seen = 1'b1;
`endif
      end
      if (bif.busy !== (k <= busy_last)) busy_err++;
      if (k == 1) begin
        bif.start = 1'b0;
        bif.S     = 32'hDEAD_BEEF;
        bif.T     = 32'h0000_0003;
      end
      if (k == inject_cyc) begin
        bif.start = 1'b1;
        bif.S     = 32'd1;
        bif.T     = 32'd1;
      end
      if (k == inject_cyc + 1) bif.start = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    bif.start = 1'b0;
    bif.FS    = 5'h00;
    bif.S     = '0;
    bif.T     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bif.busy); end
    n_checks++; if (bif.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bif.done); end
    n_checks++; if (bif.Y_lo !== 32'h0) begin n_fail++; $display("FAIL reset_ylo: got %h want 0", bif.Y_lo); end
    n_checks++; if (bif.Y_hi !== 32'h0) begin n_fail++; $display("FAIL reset_yhi: got %h want 0", bif.Y_hi); end
    n_checks++; if (bif.N !== 1'b0) begin n_fail++; $display("FAIL reset_n: got %b want 0", bif.N); end
    n_checks++; if (bif.Z !== 1'b1) begin n_fail++; $display("FAIL reset_z: got %b want 1", bif.Z); end
`ifdef DIV_ZERO_TRAP_EN
    n_checks++; if (bif.dbz !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b want 0", bif.dbz); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_fs_ignore;
    int busy_seen;
    busy_seen = 0;
    @(negedge clk);
    bif.start = 1'b1;
    bif.FS    = 5'h1E;
    bif.S     = 32'd10;
    bif.T     = 32'd2;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) bif.start = 1'b0;
      if (bif.busy !== 1'b0 || bif.done !== 1'b0) busy_seen++;
    end
    n_checks++; if (busy_seen !== 0) begin n_fail++; $display("FAIL fs_ignore: busy/done cycles %0d want 0", busy_seen); end
  endtask

  task automatic test_basic;
    int dc, dn, be; bit dz;
    run_op(32'd100, 32'd7, 1'b0, 34, 0, dc, dn, be, dz);
    n_checks++; if (dc !== 35) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want 35", dc); end
    n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", dn); end
    n_checks++; if (be !== 0) begin n_fail++; $display("FAIL basic_busy_profile: bad cycles %0d want 0", be); end
    n_checks++; if (bif.Y_lo !== 32'd14) begin n_fail++; $display("FAIL basic_ylo: got %h want %h", bif.Y_lo, 32'd14); end
    n_checks++; if (bif.Y_hi !== 32'd2) begin n_fail++; $display("FAIL basic_yhi: got %h want %h", bif.Y_hi, 32'd2); end
    n_checks++; if (bif.N !== 1'b0 || bif.Z !== 1'b0) begin n_fail++; $display("FAIL basic_nz: got N=%b Z=%b want 0 0", bif.N, bif.Z); end
`ifdef DIV_ZERO_TRAP_EN
    n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL basic_dbz: got %b want 0", dz); end
`endif
  endtask

  task automatic test_signed;
    int dc, dn, be; bit dz;
    run_op(-32'sd100, 32'd7, 1'b0, 34, 0, dc, dn, be, dz);
    n_checks++; if (bif.Y_lo !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL neg_ylo: got %h want fffffff2", bif.Y_lo); end
    n_checks++; if (bif.Y_hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL neg_yhi: got %h want fffffffe", bif.Y_hi); end
    n_checks++; if (bif.N !== 1'b1 || bif.Z !== 1'b0) begin n_fail++; $display("FAIL neg_nz: got N=%b Z=%b want 1 0", bif.N, bif.Z); end
    run_op(32'd3, 32'd7, 1'b0, 34, 0, dc, dn, be, dz);
    n_checks++; if (bif.Y_lo !== 32'h0) begin n_fail++; $display("FAIL small_ylo: got %h want 0", bif.Y_lo); end
    n_checks++; if (bif.Y_hi !== 32'd3) begin n_fail++; $display("FAIL small_yhi: got %h want 3", bif.Y_hi); end
    n_checks++; if (bif.N !== 1'b0 || bif.Z !== 1'b1) begin n_fail++; $display("FAIL small_nz: got N=%b Z=%b want 0 1", bif.N, bif.Z); end
  endtask

  task automatic test_overflow;
    int dc, dn, be; bit dz;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 34, 0, dc, dn, be, dz);
    n_checks++; if (bif.Y_lo !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_ylo: got %h want 80000000", bif.Y_lo); end
    n_checks++; if (bif.Y_hi !== 32'h0) begin n_fail++; $display("FAIL ovf_yhi: got %h want 0", bif.Y_hi); end
    n_checks++; if (bif.N !== 1'b1 || bif.Z !== 1'b0) begin n_fail++; $display("FAIL ovf_nz: got N=%b Z=%b want 1 0", bif.N, bif.Z); end
    n_checks++; if (dc !== 35) begin n_fail++; $display("FAIL ovf_done_cycle: got %0d want 35", dc); end
  endtask

  task automatic test_div_zero;
    int dc, dn, be; bit dz;
`ifdef DIV_ZERO_TRAP_EN
    run_op(32'd5, 32'd0, 1'b0, 1, 0, dc, dn, be, dz);
    n_checks++; if (dc !== 2) begin n_fail++; $display("FAIL dbz_done_cycle: got %0d want 2", dc); end
    n_checks++; if (dz !== 1'b1) begin n_fail++; $display("FAIL dbz_flag: got %b want 1", dz); end
    n_checks++; if (be !== 0) begin n_fail++; $display("FAIL dbz_busy_profile: bad cycles %0d want 0", be); end
    n_checks++; if (bif.Y_lo !== 32'h8000_0000 || bif.Y_hi !== 32'h0) begin n_fail++; $display("FAIL dbz_hold: got lo=%h hi=%h want 80000000 0", bif.Y_lo, bif.Y_hi); end
    n_checks++; if (bif.N !== 1'b1 || bif.Z !== 1'b0) begin n_fail++; $display("FAIL dbz_nz: got N=%b Z=%b want 1 0", bif.N, bif.Z); end
`else
    run_op(32'd5, 32'd0, 1'b0, 34, 0, dc, dn, be, dz);
    n_checks++; if (dc !== 35) begin n_fail++; $display("FAIL dz_done_cycle: got %0d want 35", dc); end
    n_checks++; if (bif.Y_lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_ylo: got %h want ffffffff", bif.Y_lo); end
    n_checks++; if (bif.Y_hi !== 32'd5) begin n_fail++; $display("FAIL dz_yhi: got %h want 5", bif.Y_hi); end
    n_checks++; if (bif.N !== 1'b1 || bif.Z !== 1'b0) begin n_fail++; $display("FAIL dz_nz: got N=%b Z=%b want 1 0", bif.N, bif.Z); end
`endif
  endtask

  task automatic test_reset_abort;
    int dc, dn, be; bit dz;
    int early_done;
    early_done = 0;
    @(negedge clk);
    bif.start = 1'b1;
    bif.FS    = 5'h1F;
    bif.S     = 32'd100;
    bif.T     = 32'd7;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bif.done === 1'b1) early_done++;
      if (k == 1) bif.start = 1'b0;
      if (k == 10) reset = 1'b1;
    end
    @(negedge clk);
    n_checks++; if (early_done !== 0 || bif.done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", early_done + int'(bif.done)); end
    n_checks++; if (bif.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", bif.busy); end
    n_checks++; if (bif.Y_lo !== 32'h0 || bif.Y_hi !== 32'h0) begin n_fail++; $display("FAIL abort_y: got lo=%h hi=%h want 0 0", bif.Y_lo, bif.Y_hi); end
    n_checks++; if (bif.N !== 1'b0 || bif.Z !== 1'b1) begin n_fail++; $display("FAIL abort_nz: got N=%b Z=%b want 0 1", bif.N, bif.Z); end
    reset = 1'b0;
    run_op(32'd9, 32'd2, 1'b1, 34, 0, dc, dn, be, dz);
    n_checks++; if (dc !== 35 || dn !== 1) begin n_fail++; $display("FAIL restart_done: got cycle %0d count %0d want 35 1", dc, dn); end
    n_checks++; if (bif.Y_lo !== 32'd4 || bif.Y_hi !== 32'd1) begin n_fail++; $display("FAIL restart_y: got lo=%h hi=%h want 4 1", bif.Y_lo, bif.Y_hi); end
  endtask

  task automatic test_back_to_back;
    int dc, dn, be; bit dz;
    run_op(32'd100, 32'd7, 1'b0, 34, 10, dc, dn, be, dz);
    n_checks++; if (dc !== 35 || dn !== 1) begin n_fail++; $display("FAIL b2b_done: got cycle %0d count %0d want 35 1", dc, dn); end
    n_checks++; if (be !== 0) begin n_fail++; $display("FAIL b2b_busy_profile: bad cycles %0d want 0", be); end
    n_checks++; if (bif.Y_lo !== 32'd14 || bif.Y_hi !== 32'd2) begin n_fail++; $display("FAIL b2b_y: got lo=%h hi=%h want e 2", bif.Y_lo, bif.Y_hi); end
  endtask

  initial begin
    test_reset();
    test_fs_ignore();
    test_basic();
    test_signed();
    test_overflow();
    test_div_zero();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
